// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader
// Collects a sample of NUM_FEAT feature beats into a registered vector that
// feeds a combinational decision tree. Once the vector is complete, the tree
// is given TREE_LAT cycles to settle. The class index is then captured and
// offered downstream. Only one sample is handled at a time.
//
// Ports
//   clk, rst     sole clock; synchronous active-high reset
//   s_valid      feature beat valid
//   s_ready      loader accepts a beat (LOAD and DRAIN only)
//   s_data       feature value, feature 0 first
//   s_last       final beat of a sample
//   feat_vec     registered feature vector, feature i at [FEAT_W*i +: FEAT_W]
//   tree_class   class index from the combinational tree
//   m_valid      classification result valid
//   m_ready      downstream accepts the result
//   m_class      captured class index
//   frame_err    one-cycle pulse on a sample-length error
//   sample_cnt   results accepted downstream, saturating at 0xFFFF
module dtree_feature_loader #(
  parameter int NUM_FEAT = 16,
  parameter int FEAT_W   = 8,
  parameter int CLS_W    = 4,
  parameter int TREE_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLS_W-1:0]           tree_class,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic                       frame_err,
  output logic [15:0]                sample_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {LOAD, SETTLE, OUT, DRAIN} state_t;

  state_t                     state, state_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic [3:0]                 settle, settle_n;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q;
  logic [CLS_W-1:0]           class_q;
  logic                       err_q, err_n;
  logic [15:0]                cnt_q;
  logic                       beat, wr_en, capture, done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  // Next-state and control decode. s_ready is gated with rst so the loader
  // never appears ready while it is being cleared.
  // A beat is always written in LOAD, including the one that reveals a
  // framing error, so feat_vec reflects every beat accepted in that state.
  // The settle counter is allowed to reach zero before capture, which gives
  // the tree TREE_LAT+1 edges after the last feature lands.
  always_comb begin
    s_ready  = 1'b0;
    state_n  = state;
    idx_n    = idx;
    settle_n = settle;
    err_n    = 1'b0;
    wr_en    = 1'b0;
    capture  = 1'b0;
    done     = 1'b0;

    if (!rst && (state == LOAD || state == DRAIN)) s_ready = 1'b1;
    beat = s_valid && s_ready;

    case (state)
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_n = '0;
            if (s_last) begin
              settle_n = 4'(TREE_LAT);
              state_n  = SETTLE;
            end else begin
              err_n   = 1'b1;
              state_n = DRAIN;
            end
          end else if (s_last) begin
            idx_n = '0;
            err_n = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat && s_last) state_n = LOAD;
      end
      SETTLE: begin
        if (settle == 4'd0) begin
          capture = 1'b1;
          state_n = OUT;
        end else begin
          settle_n = settle - 4'd1;
        end
      end
      OUT: begin
        if (m_ready) begin
          done    = 1'b1;
          state_n = LOAD;
        end
      end
    endcase
  end

  // Datapath registers: feature slots, captured class, error pulse and the
  // saturating result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      settle  <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      idx    <= idx_n;
      settle <= settle_n;
      err_q  <= err_n;
      if (wr_en)   feat_q[idx*FEAT_W +: FEAT_W] <= s_data;
      if (capture) class_q <= tree_class;
      if (done && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign feat_vec   = feat_q;
  assign m_valid    = (state == OUT);
  assign m_class    = class_q;
  assign frame_err  = err_q;
  assign sample_cnt = cnt_q;

endmodule

// File: doc/dtree_feature_loader.md
DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

Interface
REQ-001 Parameter NUM_FEAT, default 16, is the number of features per sample.
REQ-002 Parameter FEAT_W, default 8, is the width of one feature in bits.
REQ-003 Parameter CLS_W, default 4, is the class-index width in bits.
REQ-004 Parameter TREE_LAT, default 1, is the number of cycles allowed for the combinational tree to settle; range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 s_valid  input  1  feature beat valid.
REQ-008 s_ready  output  1  loader accepts a feature beat.
REQ-009 s_data  input  FEAT_W  feature value, sent in order feature 0 first.
REQ-010 s_last  input  1  marks the final beat of a sample.
REQ-011 feat_vec  output  NUM_FEAT*FEAT_W  registered feature vector driving the tree; feature i occupies bits [FEAT_W*i+FEAT_W-1 : FEAT_W*i].
REQ-012 tree_class  input  CLS_W  class index returned by the combinational tree.
REQ-013 m_valid  output  1  classification result valid.
REQ-014 m_ready  input  1  downstream accepts the result.
REQ-015 m_class  output  CLS_W  captured class index.
REQ-016 frame_err  output  1  one-cycle pulse on a sample-length error.
REQ-017 sample_cnt  output  16  count of results accepted downstream; saturates at 0xFFFF.

Function
REQ-018 The FSM SHALL have four states: LOAD, SETTLE, OUT and DRAIN.
REQ-019 LOAD: s_ready=1; a beat is accepted when s_valid&&s_ready; the beat writes feature slot idx, then idx increments.
REQ-020 A beat with s_last=1 at idx==NUM_FEAT-1 SHALL complete the sample: idx clears to 0, the settle counter loads TREE_LAT, and the FSM enters SETTLE.
REQ-021 Early last: a beat with s_last=1 at idx<NUM_FEAT-1 SHALL be written, then frame_err pulses, idx clears to 0, no result is produced, and the FSM stays in LOAD.
REQ-022 Missing last: a beat with s_last=0 at idx==NUM_FEAT-1 SHALL be written, then frame_err pulses, idx clears to 0, and the FSM enters DRAIN.
REQ-023 DRAIN: s_ready=1; beats are discarded without writing feat_vec; the beat with s_last=1 returns the FSM to LOAD.
REQ-024 SETTLE: s_ready=0; the settle counter decrements once per cycle; when it reaches 0, m_class captures tree_class and the FSM enters OUT with m_valid=1.
REQ-025 Latency: the cycle after the final beat is the first SETTLE cycle; m_valid rises TREE_LAT+1 cycles after the final-beat handshake.
REQ-026 OUT: s_ready=0; m_valid and m_class SHALL be held stable until m_valid&&m_ready; on that handshake, m_valid drops, sample_cnt increments, and the FSM returns to LOAD.
REQ-027 feat_vec SHALL change only on accepted LOAD beats; it stays constant throughout SETTLE and OUT.
REQ-028 At most one sample is in flight at a time; a new sample cannot begin loading until the OUT handshake completes.
REQ-029 frame_err SHALL be a registered signal asserted for exactly one cycle per error.

Reset
REQ-030 While rst=1 on a clock edge, the following SHALL be set: state=LOAD, idx=0, settle counter=0, feat_vec=0, m_class=0, m_valid=0, frame_err=0, sample_cnt=0.
REQ-031 s_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-sample or during OUT SHALL abandon the sample; no result SHALL be emitted for it.

Verification
REQ-033 Send 16 beats with values 0x10..0x1F, s_last on beat 15, tree_class=5, TREE_LAT=1, m_ready=1 -> feat_vec[7:0]=0x10 and feat_vec[127:120]=0x1F; m_valid=1 with m_class=5 two cycles after the last beat; sample_cnt=1.
REQ-034 Hold m_ready=0 for 10 cycles in OUT while tree_class toggles -> m_valid stays 1, m_class stays 5, s_ready=0, feat_vec unchanged.
REQ-035 Set s_last on beat 3 -> exactly one frame_err pulse, no m_valid; a following well-formed 16-beat sample classifies normally.
REQ-036 Send 16 beats with no s_last, then 3 more beats with s_last on the third -> frame_err pulses once, feat_vec shows only the 16 written beats, FSM back in LOAD, no result.
REQ-037 Assert rst on beat 8 of a sample -> all outputs 0; a next full sample yields a result and sample_cnt=1.
REQ-038 Preload sample_cnt to 0xFFFE and complete 3 samples -> sample_cnt=0xFFFF, no wrap.
